// File: rtl/reg_id_pkg.sv
// Shared register-ID types for the write-back encoder and the read decoder.
package reg_id_pkg;

    localparam int unsigned N_REGS = 16;
    localparam int unsigned ID_W   = 4;

    typedef logic [ID_W-1:0]   reg_id_t;
    typedef logic [N_REGS-1:0] wordline_t;

endpackage

// File: rtl/rr_pick_16.sv
// Combinational masked priority picker: first set bit of req_i at or above start_i, with wrap.
module rr_pick_16
    import reg_id_pkg::*;
(
    input  wordline_t req_i,
    input  reg_id_t   start_i,
    output logic      found_o,
    output reg_id_t   idx_o,
    output wordline_t clear_o
);

    reg_id_t cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = 0; i < N_REGS; i++) begin
            // 4-bit addition wraps past bit 15 back to bit 0
            cand = start_i + reg_id_t'(i);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
        clear_o = found_o ? (wordline_t'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/wordline_encoder_16_4.sv
// Sequential 16-to-4 write-back request encoder with valid/ready output.
// Define WORDLINE_ENC_RR_EN for round-robin pick; otherwise lowest index wins.
module wordline_encoder_16_4
    import reg_id_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  wordline_t req_i,
    input  logic      flush_i,
    output logic      out_valid_o,
    output reg_id_t   out_reg_id_o,
    input  logic      out_ready_i,
    output logic      merge_o,
    output wordline_t pending_o
);

    wordline_t pending_q, pending_d;
    logic      out_valid_q, out_valid_d;
    reg_id_t   out_id_q, out_id_d;
    logic      merge_q, merge_d;

    logic      pick_found;
    reg_id_t   pick_idx;
    wordline_t pick_clear;
    wordline_t clear_pick;
    reg_id_t   start;
    logic      slot_free;
    logic      do_pick;

`ifdef WORDLINE_ENC_RR_EN
    reg_id_t ptr_q, ptr_d;
    assign start = ptr_q;
`else
    assign start = '0;
`endif

    rr_pick_16 u_pick (
        .req_i   (pending_q),
        .start_i (start),
        .found_o (pick_found),
        .idx_o   (pick_idx),
        .clear_o (pick_clear)
    );

    assign slot_free  = !out_valid_q || out_ready_i;
    assign do_pick    = slot_free && pick_found;
    assign clear_pick = do_pick ? pick_clear : '0;

    always_comb begin
        pending_d   = (pending_q & ~clear_pick) | req_i;
        merge_d     = |(req_i & pending_q & ~clear_pick);
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        if (slot_free) begin
            out_valid_d = pick_found;
            if (pick_found) begin
                out_id_d = pick_idx;
            end
        end
    end

`ifdef WORDLINE_ENC_RR_EN
    always_comb begin
        ptr_d = do_pick ? pick_idx + reg_id_t'(1) : ptr_q;
    end

    // flush leaves the pointer where it is
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (!flush_i) begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            merge_q     <= 1'b0;
        end else if (flush_i) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            merge_q     <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            merge_q     <= merge_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_reg_id_o = out_id_q;
    assign merge_o      = merge_q;
    assign pending_o    = pending_q;

endmodule

// File: tb/tb_wordline_encoder_16_4.sv
// Self-checking bench for wordline_encoder_16_4: directed test-plan steps then random traffic.
module tb_wordline_encoder_16_4;
    import reg_id_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    wordline_t req;
    logic      flush;
    logic      out_ready;
    logic      out_valid;
    reg_id_t   out_reg_id;
    logic      merge;
    wordline_t pending;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [15:0] m_pend;
    logic        m_ov;
    int          m_id;
    logic        m_merge;
    int          m_ptr;

    always #5 clk = ~clk;

    wordline_encoder_16_4 dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .flush_i      (flush),
        .out_valid_o  (out_valid),
        .out_reg_id_o (out_reg_id),
        .out_ready_i  (out_ready),
        .merge_o      (merge),
        .pending_o    (pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Spec-level behaviour of one clock edge, using the inputs present before the edge.
    task automatic model_edge();
        int          start;
        int          pick;
        logic [15:0] clr;
        logic        free;
        if (!rst_n) begin
            m_pend = '0; m_ov = 1'b0; m_id = 0; m_merge = 1'b0; m_ptr = 0;
        end else if (flush) begin
            m_pend = '0; m_ov = 1'b0; m_merge = 1'b0;
        end else begin
`ifdef WORDLINE_ENC_RR_EN
            start = m_ptr;
`else
            start = 0;
`endif
            free = !m_ov || out_ready;
            pick = -1;
            if (free) begin
                for (int k = 0; k < 16; k++) begin
                    if (pick < 0 && m_pend[(start + k) % 16]) pick = (start + k) % 16;
                end
            end
            clr = (pick >= 0) ? (16'h1 << pick) : 16'h0;
            m_merge = |(req & m_pend & ~clr);
            m_pend  = (m_pend & ~clr) | req;
            if (free) begin
                m_ov = (pick >= 0);
                if (pick >= 0) begin
                    m_id  = pick;
                    m_ptr = (pick + 1) % 16;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_reg_id", 32'(out_reg_id), 32'(m_id));
        chk("merge", 32'(merge), 32'(m_merge));
        chk("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [31:0] r;
        rst_n = 1'b0; req = 16'hFFFF; flush = 1'b0; out_ready = 1'b1;

        // Reset with all requests asserted
        steps(2);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1; req = '0;
        step();

        // Single request: ID 5 for exactly one cycle
        req = 16'h0020; step();
        chk("single_not_yet", 32'(out_valid), 32'h0);
        req = '0; step();
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_id", 32'(out_reg_id), 32'h5);
        step();
        chk("single_done", 32'(out_valid), 32'h0);
        chk("single_pend", 32'(pending), 32'h0);

        // Reset mid-operation brings ptr back to 0, then 8003 -> 0, 1, 15
        req = 16'h0F0F; step();
        rst_n = 1'b0; req = '0; step();
        rst_n = 1'b1; req = 16'h8003; step();
        req = '0; step();
        chk("rr_id0", 32'(out_reg_id), 32'h0);
        step();
        chk("rr_id1", 32'(out_reg_id), 32'h1);
        step();
        chk("rr_id15", 32'(out_reg_id), 32'hF);
        step();
        chk("rr_empty", 32'(out_valid), 32'h0);

        // Reload 0003 -> 0, 1
        req = 16'h0003; step();
        req = '0; step();
        chk("reload_id0", 32'(out_reg_id), 32'h0);
        step();
        chk("reload_id1", 32'(out_reg_id), 32'h1);
        step();

        // Backpressure: ID 3 held while bit 0 arrives
        out_ready = 1'b0; req = 16'h0008; step();
        req = 16'h0001; step();
        chk("bp_id3", 32'(out_reg_id), 32'h3);
        steps(3);
        chk("bp_hold", 32'(out_reg_id), 32'h3);
        chk("bp_valid", 32'(out_valid), 32'h1);
        req = '0; out_ready = 1'b1; step();
        chk("bp_next0", 32'(out_reg_id), 32'h0);
        steps(2);

        // Merge on a non-picked pending bit
        out_ready = 1'b0; req = 16'h0100; step();
        req = '0; step();
        req = 16'h0080; step();
        step();
        chk("merge_pulse", 32'(merge), 32'h1);
        req = '0; step();
        chk("merge_once", 32'(merge), 32'h0);
        out_ready = 1'b1; step();
        chk("merge_id7", 32'(out_reg_id), 32'h7);
        steps(2);

        // Re-request in the pick cycle: no merge, issued twice
        req = 16'h0080; step();
        step();
        chk("rereq_nomerge", 32'(merge), 32'h0);
        chk("rereq_first", 32'(out_reg_id), 32'h7);
        req = '0; step();
        chk("rereq_second", 32'(out_reg_id), 32'h7);
        chk("rereq_valid", 32'(out_valid), 32'h1);
        steps(2);

        // Flush discards pending, held output and same-cycle request
        out_ready = 1'b0; req = 16'h0F00; step();
        req = '0; step();
        flush = 1'b1; req = 16'h0001; step();
        chk("flush_valid", 32'(out_valid), 32'h0);
        chk("flush_pend", 32'(pending), 32'h0);
        flush = 1'b0; req = '0; out_ready = 1'b1; steps(2);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = $urandom & $urandom;
            req = ($urandom_range(0, 3) == 0) ? r[15:0] : 16'h0;
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            rst_n = ($urandom_range(0, 63) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wordline_encoder_16_4.md
# wordline_encoder_16_4

Sequential 16-to-4 request encoder for the register file write-back side; it turns wordline-style request vectors into a stream of 4-bit register IDs. Per-register write-back requests arrive as a 16-bit multi-hot vector and are latched into a pending mask. The block issues one register ID per accepted handshake, using round-robin selection. It sits between the write-back request sources and the register file write port, which consumes the ID through a valid/ready handshake.

## Interface
- N_REGS, 16, number of request lines / registers
- ID_W, 4, register ID width; must equal log2(N_REGS)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- req_in  input  N_REGS  request pulses; bit i high = register i needs issue; multi-hot allowed
- flush  input  1  synchronous clear of all pending and output state
- out_valid  output  1  out_reg_id is valid
- out_reg_id  output  ID_W  encoded register ID
- out_ready  input  1  consumer accepts out_reg_id this cycle
- merge  output  1  one-cycle pulse: a req_in bit hit an already-pending bit
- pending  output  N_REGS  current pending mask (debug/scoreboard)

## Operation
- State: pending mask, output register (out_valid, out_reg_id), round-robin pointer ptr (ID_W bits).
- Accept event = out_valid & out_ready.
- Load slot free = !out_valid | accept.
- Pick: first set bit of pending, scanning upward from ptr with wrap past bit 15 to bit 0.
- On a free slot with a non-zero pending mask, these happen at the same edge:
  - pick is loaded into out_reg_id and out_valid goes to 1
  - the picked bit is cleared from pending
  - ptr becomes pick+1 (mod 16)
- Pending update: pending_next = (pending & ~clear_pick) | req_in.
  - A request on the bit being picked in the same cycle stays pending, so it is issued again later.
- merge = |(req_in & pending & ~clear_pick), registered, one-cycle pulse.
- Holding: while out_valid & !out_ready, out_reg_id is stable and the pick is not performed.
- Empty mask on a free slot: out_valid goes to 0 after an accept, or stays 0.
- flush (priority below rst_n, above everything else):
  - pending, out_valid and merge go to 0 next edge; req_in in that cycle is discarded
  - ptr is unchanged
- Reset values: pending=0, out_valid=0, out_reg_id=0, merge=0, ptr=0.
- Reset mid-operation drops all pending requests and any held output, with no handshake.

## Timing
- Latency: a req_in bit sampled at edge N is in pending after N; it is presented as out_valid after N+1 at the earliest, if the slot is free.
- Throughput: one ID per cycle while out_ready is held high and pending is non-empty.
- out_valid, out_reg_id and merge are registered.
  - No combinational path from req_in or out_ready to any output.
- pending output reflects register state, not the next-state value.

## Configuration
- WORDLINE_ENC_RR_EN defined: round-robin pick from ptr, as above.
- WORDLINE_ENC_RR_EN undefined: fixed priority, lowest set index wins.
  - ptr is removed; it is not a register and is treated as 0.
  - Starvation of high indices is accepted.

## Structure
- Shared package reg_id_pkg holds:
  - N_REGS = 16 and ID_W = 4
  - typedef reg_id_t (ID_W bits) and wordline_t (N_REGS bits), also used by the read decoder
- Sub-module rr_pick_16: combinational masked priority picker.
  - Inputs: request mask and start pointer.
  - Outputs: found flag, index, and one-hot clear vector.
  - Instantiated once; with round-robin disabled, its start pointer is tied to 0.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req_in=16'hFFFF -> out_valid=0, pending=0, merge=0 after release; the first issue appears 2 cycles after the first req_in.
- Single request: req_in=16'h0020 for one cycle, out_ready=1 -> out_reg_id=5 with out_valid for exactly one cycle, and pending=0 afterwards.
- Round-robin: pending=16'h8003 with ptr=0 and out_ready=1 -> IDs 0, 1, 15, then out_valid=0.
  - Reload 16'h0003 with ptr=0 -> 0, 1.
  - Undefined macro with 16'h8003 -> 0, 1, 15.
- Backpressure: out_valid with out_reg_id=3 and out_ready=0 for 4 cycles while req_in=16'h0001 arrives -> ID stays 3; after out_ready=1 the next ID is 0.
- Merge and re-request: pending bit 7 set and req_in=16'h0080 while bit 7 is not picked -> merge pulses once and bit 7 is issued once.
  - Same req_in in the cycle bit 7 is picked -> no merge, and ID 7 is issued twice.
- Flush: pending=16'h0F00 with out_valid=1, flush=1 together with req_in=16'h0001 -> next cycle out_valid=0 and pending=0.
